// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: LDM/STM multi-register transfer sequencer.
// Steps the register bank one register per memory beat, with optional base writeback. Rev 1.0
`default_nettype none

module ldm_stm_sequencer #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [4:0]        rb_addr,
  output logic              rb_w,
  output logic [ADDR_W-1:0] rb_wdata,
  output logic              rb_pc_w,
  output logic [ADDR_W-1:0] rb_pc_wdata,
  input  logic [ADDR_W-1:0] rb_read1,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(WORD_BYTES);

  logic [1:0]        r_state;
  logic [15:0]       r_list;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_base_reg;
  logic              r_is_load;
  logic              r_wback;
  logic [ADDR_W-1:0] r_wb_val;
  logic              r_wb_sup;

  logic [4:0]        w_cnt;
  logic [ADDR_W-1:0] w_span;
  logic [ADDR_W-1:0] w_start_addr;
  logic [3:0]        w_idx;
  logic              w_last;
  logic              w_ld_ack;
  logic              w_wb_en;
  logic              w_rb_w_ld;
  logic              w_rb_pc_ld;
  logic              w_rb_w_wb;
  logic              w_rb_pc_wb;

  always_comb begin
    w_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_cnt = w_cnt + {4'd0, reg_list[i]};
    end
  end

  assign w_span = ADDR_W'(w_cnt) * C_STEP;

  // Lowest register always lands on the lowest address, so descending modes start low too.
  always_comb begin
    case ({up, pre})
      2'b10:   w_start_addr = base_val;
      2'b11:   w_start_addr = base_val + C_STEP;
      2'b00:   w_start_addr = base_val - w_span + C_STEP;
      default: w_start_addr = base_val - w_span;
    endcase
  end

  always_comb begin
    w_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_list[i]) w_idx = i[3:0];
    end
  end

  assign w_last = ((r_list & (r_list - 16'd1)) == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_list     <= 16'd0;
      r_addr     <= '0;
      r_base_reg <= 4'd0;
      r_is_load  <= 1'b0;
      r_wback    <= 1'b0;
      r_wb_val   <= '0;
      r_wb_sup   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_list     <= reg_list;
            r_addr     <= w_start_addr;
            r_base_reg <= base_reg;
            r_is_load  <= is_load;
            r_wback    <= wback;
            r_wb_val   <= up ? (base_val + w_span) : (base_val - w_span);
            r_wb_sup   <= is_load & reg_list[base_reg];
            r_state    <= (w_cnt == 5'd0) ? S_DONE : S_XFER;
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            r_list <= r_list & ~(16'd1 << w_idx);
            r_addr <= r_addr + C_STEP;
            if (w_last) r_state <= r_wback ? S_WB : S_DONE;
          end
        end
        S_WB:    r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mem_req   = (r_state == S_XFER);
  assign mem_we    = (r_state == S_XFER) & ~r_is_load;
  assign mem_addr  = r_addr;
  assign mem_wdata = rb_read1;

  // A loaded PC goes through the PC port, never the general write port.
  assign w_ld_ack   = (r_state == S_XFER) & mem_ack & r_is_load;
  assign w_wb_en    = (r_state == S_WB) & ~r_wb_sup;
  assign w_rb_w_ld  = w_ld_ack & (w_idx != 4'hF);
  assign w_rb_pc_ld = w_ld_ack & (w_idx == 4'hF);
  assign w_rb_w_wb  = w_wb_en & (r_base_reg != 4'hF);
  assign w_rb_pc_wb = w_wb_en & (r_base_reg == 4'hF);

  assign rb_w    = w_rb_w_ld | w_rb_w_wb;
  assign rb_pc_w = w_rb_pc_ld | w_rb_pc_wb;

  always_comb begin
    rb_addr     = 5'd0;
    rb_wdata    = '0;
    rb_pc_wdata = '0;
    if (r_state == S_XFER) rb_addr = {1'b0, w_idx};
    else if (r_state == S_WB) rb_addr = {1'b0, r_base_reg};
    if (w_rb_w_ld) rb_wdata = mem_rdata;
    else if (w_rb_w_wb) rb_wdata = r_wb_val;
    if (w_rb_pc_ld) rb_pc_wdata = mem_rdata;
    else if (w_rb_pc_wb) rb_pc_wdata = r_wb_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed self-checking bench for ldm_stm_sequencer.
`default_nettype none

module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] reg_list = 16'd0;
  logic [3:0]  base_reg = 4'd0;
  logic [31:0] base_val = 32'd0;
  logic        is_load = 1'b0;
  logic        up = 1'b0;
  logic        pre = 1'b0;
  logic        wback = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack = 1'b0;
  logic [4:0]  rb_addr;
  logic        rb_w;
  logic [31:0] rb_wdata;
  logic        rb_pc_w;
  logic [31:0] rb_pc_wdata;
  logic [31:0] rb_read1;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  ldm_stm_sequencer #(.WORD_BYTES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_list(reg_list), .base_reg(base_reg),
    .base_val(base_val), .is_load(is_load), .up(up), .pre(pre), .wback(wback),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rb_addr(rb_addr), .rb_w(rb_w),
    .rb_wdata(rb_wdata), .rb_pc_w(rb_pc_w), .rb_pc_wdata(rb_pc_wdata),
    .rb_read1(rb_read1), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bank and memory models: read data is a fixed function of the address presented.
  assign rb_read1  = 32'hA000_0000 | {27'd0, rb_addr};
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

  task automatic go(input logic [15:0] l, input logic [3:0] br, input logic [31:0] bv,
                    input logic ld, input logic u, input logic p, input logic wb);
    @(negedge clk);
    reg_list = l; base_reg = br; base_val = bv; is_load = ld; up = u; pre = p; wback = wb;
    start = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, rb_w, rb_pc_w, busy, done} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got req/we/w/pcw/busy/done=%b want 000000",
                      {mem_req, mem_we, rb_w, rb_pc_w, busy, done});
    end
    total++;
    if (mem_addr !== 32'd0 || rb_addr !== 5'd0 || rb_wdata !== 32'd0 || rb_pc_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_data got addr=%h rb_addr=%0d wdata=%h pcw=%h want all 0",
                      mem_addr, rb_addr, rb_wdata, rb_pc_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_stm_ia();
    logic [31:0] ea;
    go(16'h000E, 4'd5, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0; mem_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) @(negedge clk);
      #1;
      ea = 32'h100 + 32'(4 * b);
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea) begin
        bad++; $display("FAIL stm_ia_beat%0d got req=%b we=%b addr=%h want 1 1 %h", b, mem_req, mem_we, mem_addr, ea);
      end
      total++;
      if (rb_addr !== 5'(b + 1) || mem_wdata !== (32'hA000_0000 | 32'(b + 1)) || rb_w !== 1'b0 || rb_pc_w !== 1'b0) begin
        bad++; $display("FAIL stm_ia_bank%0d got rb_addr=%0d wdata=%h w=%b pcw=%b want %0d %h 0 0",
                        b, rb_addr, mem_wdata, rb_w, rb_pc_w, b + 1, 32'hA000_0000 | 32'(b + 1));
      end
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b1 || mem_req !== 1'b0 || rb_w !== 1'b0) begin
      bad++; $display("FAIL stm_ia_done got done=%b req=%b w=%b want 1 0 0", done, mem_req, rb_w);
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL stm_ia_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_ldm_db();
    logic [31:0] ea;
    logic [4:0]  ei;
    go(16'h8003, 4'd4, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk); start = 1'b0; mem_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) @(negedge clk);
      #1;
      ea = 32'h1F4 + 32'(4 * b);
      ei = (b == 2) ? 5'd15 : 5'(b);
      total++;
      if (mem_addr !== ea || rb_addr !== ei || mem_we !== 1'b0 || mem_req !== 1'b1) begin
        bad++; $display("FAIL ldm_db_beat%0d got addr=%h rb_addr=%0d we=%b req=%b want %h %0d 0 1",
                        b, mem_addr, rb_addr, mem_we, mem_req, ea, ei);
      end
      total++;
      if (b < 2) begin
        if (rb_w !== 1'b1 || rb_wdata !== (ea ^ 32'h5A5A_0000) || rb_pc_w !== 1'b0) begin
          bad++; $display("FAIL ldm_db_wr%0d got w=%b wdata=%h pcw=%b want 1 %h 0", b, rb_w, rb_wdata, rb_pc_w, ea ^ 32'h5A5A_0000);
        end
      end else begin
        if (rb_pc_w !== 1'b1 || rb_pc_wdata !== (ea ^ 32'h5A5A_0000) || rb_w !== 1'b0) begin
          bad++; $display("FAIL ldm_db_pc got pcw=%b pcwdata=%h w=%b want 1 %h 0", rb_pc_w, rb_pc_wdata, rb_w, ea ^ 32'h5A5A_0000);
        end
      end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    total++;
    if (rb_w !== 1'b1 || rb_addr !== 5'd4 || rb_wdata !== 32'h1F4 || rb_pc_w !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL ldm_db_wb got w=%b rb_addr=%0d wdata=%h pcw=%b req=%b want 1 4 000001f4 0 0",
                      rb_w, rb_addr, rb_wdata, rb_pc_w, mem_req);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL ldm_db_done got done=%b want 1", done);
    end
  endtask

  task automatic test_ldm_base_in_list();
    go(16'h0004, 4'd2, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0; mem_ack = 1'b1; #1;
    total++;
    if (mem_addr !== 32'h300 || rb_addr !== 5'd2 || rb_w !== 1'b1 || rb_wdata !== 32'h5A5A_0300) begin
      bad++; $display("FAIL base_in_list_beat got addr=%h rb_addr=%0d w=%b wdata=%h want 00000300 2 1 5a5a0300",
                      mem_addr, rb_addr, rb_w, rb_wdata);
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    total++;
    if (rb_w !== 1'b0 || rb_pc_w !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL base_in_list_wb got w=%b pcw=%b busy=%b done=%b req=%b want 0 0 1 0 0",
                      rb_w, rb_pc_w, busy, done, mem_req);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL base_in_list_done got done=%b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_empty_list();
    go(16'h0000, 4'd3, 32'h700, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0; #1;
    total++;
    if (done !== 1'b1 || mem_req !== 1'b0 || rb_w !== 1'b0 || rb_pc_w !== 1'b0) begin
      bad++; $display("FAIL empty_done got done=%b req=%b w=%b pcw=%b want 1 0 0 0", done, mem_req, rb_w, rb_pc_w);
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || rb_w !== 1'b0) begin
      bad++; $display("FAIL empty_idle got busy=%b done=%b w=%b want 0 0 0", busy, done, rb_w);
    end
  endtask

  task automatic test_da_pc_wb();
    go(16'h0003, 4'd15, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0; mem_ack = 1'b1; #1;
    total++;
    if (mem_addr !== 32'h4FC || rb_addr !== 5'd0) begin
      bad++; $display("FAIL da_beat0 got addr=%h rb_addr=%0d want 000004fc 0", mem_addr, rb_addr);
    end
    @(negedge clk); #1;
    total++;
    if (mem_addr !== 32'h500 || rb_addr !== 5'd1) begin
      bad++; $display("FAIL da_beat1 got addr=%h rb_addr=%0d want 00000500 1", mem_addr, rb_addr);
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    total++;
    if (rb_pc_w !== 1'b1 || rb_pc_wdata !== 32'h4F8 || rb_w !== 1'b0 || rb_addr !== 5'd15) begin
      bad++; $display("FAIL da_pc_wb got pcw=%b pcwdata=%h w=%b rb_addr=%0d want 1 000004f8 0 15",
                      rb_pc_w, rb_pc_wdata, rb_w, rb_addr);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL da_done got done=%b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_and_reset();
    go(16'h0007, 4'd6, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0; mem_ack = 1'b1; #1;
    total++;
    if (mem_addr !== 32'h400 || rb_addr !== 5'd0) begin
      bad++; $display("FAIL wait_beat0 got addr=%h rb_addr=%0d want 00000400 0", mem_addr, rb_addr);
    end
    for (int w = 0; w < 4; w++) begin
      @(negedge clk); mem_ack = (w == 3); #1;
      total++;
      if (mem_addr !== 32'h404 || rb_addr !== 5'd1 || mem_req !== 1'b1 || mem_wdata !== 32'hA000_0001) begin
        bad++; $display("FAIL wait_hold%0d got addr=%h rb_addr=%0d req=%b wdata=%h want 00000404 1 1 a0000001",
                        w, mem_addr, rb_addr, mem_req, mem_wdata);
      end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    total++;
    if (mem_addr !== 32'h408 || rb_addr !== 5'd2) begin
      bad++; $display("FAIL wait_beat2 got addr=%h rb_addr=%0d want 00000408 2", mem_addr, rb_addr);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({mem_req, mem_we, rb_w, rb_pc_w, busy, done} !== 6'b0 || mem_addr !== 32'd0 || rb_addr !== 5'd0) begin
      bad++; $display("FAIL midreset got ctrl=%b addr=%h rb_addr=%0d want 000000 0 0",
                      {mem_req, mem_we, rb_w, rb_pc_w, busy, done}, mem_addr, rb_addr);
    end
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || rb_w !== 1'b0) begin
        bad++; $display("FAIL midreset_after%0d got done=%b busy=%b w=%b want 0 0 0", c, done, busy, rb_w);
      end
    end
  endtask

  task automatic test_wrap_and_busy_start();
    go(16'h0001, 4'd1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reg_list = 16'hFFFF; base_val = 32'h1234; start = 1'b1; mem_ack = 1'b0; #1;
    total++;
    if (mem_addr !== 32'd0 || rb_addr !== 5'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL wrap_addr got addr=%h rb_addr=%0d busy=%b want 00000000 0 1", mem_addr, rb_addr, busy);
    end
    @(negedge clk); start = 1'b0; mem_ack = 1'b1; #1;
    total++;
    if (mem_addr !== 32'd0 || rb_addr !== 5'd0 || mem_req !== 1'b1) begin
      bad++; $display("FAIL busy_start_ignored got addr=%h rb_addr=%0d req=%b want 00000000 0 1", mem_addr, rb_addr, mem_req);
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    total++;
    if (done !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL wrap_done got done=%b req=%b want 1 0", done, mem_req);
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL wrap_idle got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_stm_ia();
    test_ldm_db();
    test_ldm_base_in_list();
    test_empty_list();
    test_da_pc_wb();
    test_wait_and_reset();
    test_wrap_and_busy_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
